// File: rtl/lc3_imm_extract.sv
//==============================================================================
// Module   : lc3_imm_extract
// Purpose  : LC-3 immediate/offset field extraction with sign/zero extension,
//            buffered through a DEPTH-entry result FIFO.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module lc3_imm_extract #(
    parameter int OUT_WIDTH = 16,
    parameter int DEPTH     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [15:0]                  in_instr,
    input  logic [2:0]                   in_mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic                         out_err,
    output logic [$clog2(DEPTH+1)-1:0]   out_count
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH+1);
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
    localparam logic [c_PW-1:0] c_LAST  = c_PW'(DEPTH-1);

    logic [OUT_WIDTH-1:0] r_data [DEPTH];
    logic                 r_err  [DEPTH];
    logic [c_PW-1:0]      r_head;
    logic [c_PW-1:0]      r_tail;
    logic [c_CW-1:0]      r_count;

    logic [OUT_WIDTH-1:0] w_ext;
    logic                 w_err;
    logic                 w_push;
    logic                 w_pop;

    // Explicit wrap so non-power-of-two depths cycle through exactly DEPTH slots.
    function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_ext = '0;
        w_err = 1'b0;
        case (in_mode)
            3'd0:    w_ext = OUT_WIDTH'($signed(in_instr[4:0]));
            3'd1:    w_ext = OUT_WIDTH'($signed(in_instr[5:0]));
            3'd2:    w_ext = OUT_WIDTH'($signed(in_instr[8:0]));
            3'd3:    w_ext = OUT_WIDTH'($signed(in_instr[10:0]));
            3'd4:    w_ext = OUT_WIDTH'(in_instr[7:0]);
            3'd5:    w_ext = OUT_WIDTH'($signed(in_instr[15:0]));
            default: w_err = 1'b1;
        endcase
    end

    assign in_ready  = (r_count < c_DEPTH);
    assign out_valid = (r_count != '0);
    assign out_count = r_count;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Empty FIFO presents zeros rather than stale slot contents.
    assign out_data  = out_valid ? r_data[r_head] : '0;
    assign out_err   = out_valid ? r_err[r_head]  : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= f_next(r_tail);
            if (w_pop)  r_head <= f_next(r_head);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_data[r_tail] <= w_ext;
            r_err[r_tail]  <= w_err;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lc3_imm_extract.sv
//==============================================================================
// Module   : tb_lc3_imm_extract
// Purpose  : Three configurations of lc3_imm_extract driven in parallel and
//            compared every cycle against a queue-based reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_lc3_imm_extract;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_instr;
    logic [2:0]  in_mode;
    logic        out_ready;

    logic [2:0]  rdy;
    logic [2:0]  ov;
    logic [2:0]  oe;
    logic [15:0] d0_data;
    logic [31:0] d1_data;
    logic [15:0] d2_data;
    logic [1:0]  d0_cnt;
    logic [1:0]  d1_cnt;
    logic [2:0]  d2_cnt;

    int vectors;
    int miscompares;

    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [32:0] q2[$];

    lc3_imm_extract #(.OUT_WIDTH(16), .DEPTH(2)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_instr(in_instr), .in_mode(in_mode), .out_valid(ov[0]),
        .out_ready(out_ready), .out_data(d0_data), .out_err(oe[0]), .out_count(d0_cnt)
    );
    lc3_imm_extract #(.OUT_WIDTH(32), .DEPTH(3)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_instr(in_instr), .in_mode(in_mode), .out_valid(ov[1]),
        .out_ready(out_ready), .out_data(d1_data), .out_err(oe[1]), .out_count(d1_cnt)
    );
    lc3_imm_extract #(.OUT_WIDTH(16), .DEPTH(5)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_instr(in_instr), .in_mode(in_mode), .out_valid(ov[2]),
        .out_ready(out_ready), .out_data(d2_data), .out_err(oe[2]), .out_count(d2_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cfg_depth(int k);
        return (k == 0) ? 2 : (k == 1) ? 3 : 5;
    endfunction

    function automatic int cfg_width(int k);
        return (k == 1) ? 32 : 16;
    endfunction

    function automatic logic [31:0] dut_data(int k);
        return (k == 0) ? {16'h0, d0_data} : (k == 1) ? d1_data : {16'h0, d2_data};
    endfunction

    function automatic int dut_cnt(int k);
        return (k == 0) ? int'(d0_cnt) : (k == 1) ? int'(d1_cnt) : int'(d2_cnt);
    endfunction

    function automatic int q_size(int k);
        return (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    endfunction

    function automatic logic [32:0] q_head(int k);
        if (q_size(k) == 0) return 33'h0;
        return (k == 0) ? q0[0] : (k == 1) ? q1[0] : q2[0];
    endfunction

    task automatic q_push(int k, logic [32:0] v);
        if (k == 0) q0.push_back(v);
        else if (k == 1) q1.push_back(v);
        else q2.push_back(v);
    endtask

    task automatic q_pop(int k);
        if (k == 0) void'(q0.pop_front());
        else if (k == 1) void'(q1.pop_front());
        else void'(q2.pop_front());
    endtask

    // Reference: take the low n bits as an integer, reinterpret as two's
    // complement when signed, then reduce modulo 2^width. Bit 32 is err.
    function automatic logic [32:0] model_ext(int mode, logic [15:0] instr, int width);
        int     n;
        longint v;
        logic [63:0] u;
        case (mode)
            0: n = 5;
            1: n = 6;
            2: n = 9;
            3: n = 11;
            4: n = 8;
            5: n = 16;
            default: return {1'b1, 32'h0};
        endcase
        v = longint'(instr) % (longint'(1) << n);
        if (mode != 4 && v >= (longint'(1) << (n - 1))) v = v - (longint'(1) << n);
        u = 64'(v);
        u = u % (64'd1 << width);
        return {1'b0, u[31:0]};
    endfunction

    task automatic chk(string tag, int k, logic [63:0] obs, logic [63:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s dut%0d t=%0t observed=%0h expected=%0h", tag, k, $time, obs, exp);
            $error("%s dut%0d differs", tag, k);
        end
    endtask

    // Check every DUT against the model, then advance one clock and update it.
    task automatic step();
        bit          push [3];
        bit          pop  [3];
        logic [32:0] ent  [3];
        for (int k = 0; k < 3; k++) begin
            int          sz;
            logic [32:0] h;
            sz = q_size(k);
            h  = q_head(k);
            chk("in_ready",  k, 64'(rdy[k]),      64'(sz < cfg_depth(k)));
            chk("out_valid", k, 64'(ov[k]),       64'(sz > 0));
            chk("out_count", k, 64'(dut_cnt(k)),  64'(sz));
            chk("out_data",  k, 64'(dut_data(k)), 64'(h[31:0]));
            chk("out_err",   k, 64'(oe[k]),       64'(h[32]));
            push[k] = in_valid && (sz < cfg_depth(k));
            pop[k]  = (sz > 0) && out_ready;
            ent[k]  = model_ext(int'(in_mode), in_instr, cfg_width(k));
        end
        vectors++;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (pop[k])  q_pop(k);
            if (push[k]) q_push(k, ent[k]);
        end
        @(negedge clk);
    endtask

    task automatic exp_head(int k, logic [31:0] d, logic e);
        chk("head_valid", k, 64'(ov[k]),       64'd1);
        chk("head_data",  k, 64'(dut_data(k)), 64'(d));
        chk("head_err",   k, 64'(oe[k]),       64'(e));
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        out_ready = 1'b0;
    endtask

    task automatic one(logic [2:0] mode, logic [15:0] instr, logic [31:0] e16, logic [31:0] e32);
        in_valid = 1'b1;
        in_mode  = mode;
        in_instr = instr;
        step();
        in_valid = 1'b0;
        exp_head(0, e16, 1'b0);
        exp_head(1, e32, 1'b0);
        exp_head(2, e16, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic reset_check();
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", k, 64'(ov[k]),       64'd0);
            chk("rst_count", k, 64'(dut_cnt(k)),  64'd0);
            chk("rst_ready", k, 64'(rdy[k]),      64'd1);
            chk("rst_data",  k, 64'(dut_data(k)), 64'd0);
            chk("rst_err",   k, 64'(oe[k]),       64'd0);
        end
        q0.delete();
        q1.delete();
        q2.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_instr    = 16'h0;
        in_mode     = 3'd0;
        out_ready   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Per-mode extension values, 16- and 32-bit results side by side.
        one(3'd0, 16'h1010, 32'h0000FFF0, 32'hFFFFFFF0);
        one(3'd1, 16'h601F, 32'h0000001F, 32'h0000001F);
        one(3'd1, 16'h0020, 32'h0000FFE0, 32'hFFFFFFE0);
        one(3'd2, 16'h0100, 32'h0000FF00, 32'hFFFFFF00);
        one(3'd3, 16'h43FF, 32'h000003FF, 32'h000003FF);
        one(3'd4, 16'hF0FF, 32'h000000FF, 32'h000000FF);
        one(3'd5, 16'h8001, 32'h00008001, 32'hFFFF8001);
        one(3'd2, 16'h00FF, 32'h000000FF, 32'h000000FF);

        // Illegal modes keep their slots, in order, followed by a legal entry.
        in_valid = 1'b1;
        in_instr = 16'hFFFF;
        in_mode  = 3'd6;
        step();
        in_mode  = 3'd7;
        step();
        in_mode  = 3'd0;
        in_instr = 16'h0001;
        step();
        in_valid = 1'b0;
        exp_head(1, 32'h0, 1'b1);
        out_ready = 1'b1;
        step();
        exp_head(1, 32'h0, 1'b1);
        step();
        exp_head(1, 32'h1, 1'b0);
        drain();

        // Backpressure on the depth-3 instance, then wrap with order preserved.
        in_valid = 1'b1;
        in_mode  = 3'd4;
        in_instr = 16'h0011;
        step();
        in_instr = 16'h0022;
        step();
        in_instr = 16'h0033;
        step();
        in_instr = 16'h0044;
        chk("full_ready", 1, 64'(rdy[1]),     64'd0);
        chk("full_count", 1, 64'(dut_cnt(1)), 64'd3);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("refill_ready", 1, 64'(rdy[1]),     64'd1);
        chk("refill_count", 1, 64'(dut_cnt(1)), 64'd2);
        step();
        in_valid = 1'b0;
        exp_head(1, 32'h22, 1'b0);
        out_ready = 1'b1;
        step();
        exp_head(1, 32'h33, 1'b0);
        step();
        exp_head(1, 32'h44, 1'b0);
        drain();

        // Reset with entries buffered, then a push on the first live edge.
        in_valid = 1'b1;
        in_mode  = 3'd5;
        in_instr = 16'h1234;
        step();
        in_instr = 16'h5678;
        step();
        reset_check();
        in_instr = 16'h00AB;
        step();
        in_valid = 1'b0;
        exp_head(1, 32'h000000AB, 1'b0);
        drain();

        // Random stall soak.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            in_mode   = 3'($urandom_range(0, 7));
            in_instr  = 16'($urandom);
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
